adc_osr_reader: RTL and testbench
=================================

Name: adc_osr_reader

Overview:
- System-clock-side consumer of the oversampler output.
- Synchronises the oversampler's asynchronous completion strobe into `clk` and captures each 16-bit result.
- Buffers results in a small first-word-fall-through FIFO and presents them on a valid/ready read port to the host/Wishbone glue.
- Tracks the accepted-sample count and a sticky overflow flag.

Parameters:
- FIFO_DEPTH, 4, number of buffered results; power of two, at least 2.
- SYNC_STAGES, 2, flops in the done-strobe synchroniser; at least 2.
- DATA_W, 16, result width; must equal the oversampler output width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- osr_data_in  input  DATA_W  oversampler result; stable from done rising until the next strobe rising edge
- osr_done_in  input  1  oversampler conversion-finished strobe, asynchronous to clk
- enable_in  input  1  1 = accept new results
- rd_ready_in  input  1  consumer ready
- rd_valid_out  output  1  FIFO head valid
- rd_data_out  output  DATA_W  FIFO head data
- fifo_level_out  output  clog2(FIFO_DEPTH)+1  entries held
- overflow_out  output  1  sticky: a result was dropped
- overflow_clr_in  input  1  clears overflow_out
- sample_count_out  output  16  results accepted since reset

Behaviour:
- Clock and reset: single clock `clk`; reset is asynchronous and active-low (`rst_n`). All flops reset asynchronously.
- Reset values:
  - rd_valid_out=0, rd_data_out=0, fifo_level_out=0, overflow_out=0, sample_count_out=0.
  - Synchroniser and edge flops = 0.
  - FIFO pointers = 0; memory contents don't-care, but rd_data_out is forced to 0 while empty.
- Synchroniser:
  - osr_done_in → SYNC_STAGES flops → one edge flop.
  - capture = last_sync & ~edge_flop: a one-cycle pulse per rising edge of done.
  - A done that is high at reset release produces one capture. The oversampler shares rst_n, so this does not occur in-system.
- Latency (SYNC_STAGES=2): done first sampled high at edge E0 → capture high during E1..E2 → osr_data_in written to the FIFO at E2 → rd_valid_out=1 after E2.
- Data is sampled at the write edge, never at the done edge.
- Source constraint: strobe period ≥ SYNC_STAGES+2 clk periods; shorter periods are unsupported (results may be merged or lost).
- Push = capture & enable_in.
  - enable_in=0: capture is ignored entirely (no write, no count, no overflow).
  - Pop and drain continue while disabled.
- Pop = rd_valid_out & rd_ready_in.
  - rd_data_out shows mem[rd_ptr] combinationally from the registered pointer (FWFT).
  - rd_valid_out = (level != 0).
- Boundary conditions:
  - Empty and push: head becomes valid the next cycle; no same-cycle bypass.
  - Empty and rd_ready_in=1 with no push: no pop; pointers unchanged.
  - Full, push and pop in the same cycle: both happen, level stays FIFO_DEPTH, no overflow.
  - Full and push without pop: new sample dropped, FIFO unchanged, overflow_out←1, sample_count_out unchanged.
  - Pointers wrap modulo FIFO_DEPTH; level uses a separate up/down counter. Push-only +1, pop-only −1, both 0.
- Overflow flag: overflow_clr_in=1 clears it; if clear and a new drop occur in the same cycle, set wins.
- sample_count_out: +1 per accepted push; wraps 16'hFFFF→16'h0000 with no flag.
- Reset mid-operation: all state cleared immediately. Any in-flight capture is discarded and buffered data is lost.

Decomposition:
- Shared package adc_osr_pkg:
  - ADC_OSR_DATA_W=16.
  - OSR mode encodings: 3'b000 bypass, 001 ×4, 010 ×16, 011 ×64, 100 ×256.
  - ADC_OSR_MAX_SAMPLES=256.
- Sub-module adc_strobe_sync:
  - Ports: clk, rst_n, async_in, pulse_out; parameter SYNC_STAGES.
  - Reusable for other async strobes in the ADC path.
- FIFO and counters stay inline.

Test Plan:
- Single result: after reset, osr_data_in=16'hABC0, done pulsed high 6 clk → rd_valid_out=1 exactly 3 edges after done first sampled; rd_data_out=16'hABC0; sample_count_out=1. Then rd_ready_in=1 for one cycle → rd_valid_out=0, level=0.
- Fill and overflow: rd_ready_in=0, 5 strobes with data 1,2,3,4,5 → level=4, overflow_out=1, count=4. Drain with rd_ready_in=1 → reads 1,2,3,4.
- Full with simultaneous push and pop: FIFO holding 1..4, rd_ready_in=1 in the capture cycle of data 9 → overflow_out stays 0, level=4. Drain order 2,3,4,9.
- Enable gating: enable_in=0, 3 strobes → level=0, count=0, overflow_out=0. Set enable_in=1, one strobe → level=1.
- Overflow clear priority: overflow_clr_in=1 in the same cycle as a dropped push → overflow_out=1. Clear in a later idle cycle → 0.
- Reset mid-stream and counter wrap:
  - Assert rst_n=0 with level=3 and a done in flight → all outputs 0 immediately; after release, no spurious rd_valid_out.
  - Force the count to 16'hFFFF via 65535 pushes with continuous drain, one more push → sample_count_out=0.

Source files
------------

// File: rtl/adc_osr_pkg.sv
// Shared definitions for the ADC oversampling path: result width, OSR mode
// encodings and the largest oversampling ratio.
package adc_osr_pkg;

  localparam int ADC_OSR_DATA_W      = 16;
  localparam int ADC_OSR_MAX_SAMPLES = 256;

  typedef enum logic [2:0] {
    OSR_BYPASS = 3'b000,
    OSR_X4     = 3'b001,
    OSR_X16    = 3'b010,
    OSR_X64    = 3'b011,
    OSR_X256   = 3'b100
  } osr_mode_e;

endpackage

// File: rtl/adc_strobe_sync.sv
// Brings an asynchronous strobe into clk and emits a one-cycle pulse per
// rising edge of the strobe.
module adc_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign pulse_out = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/adc_osr_reader.sv
// System-clock consumer of oversampler results: synchronises the done strobe,
// buffers results in a FWFT FIFO and tracks accepted count and overflow.
module adc_osr_reader
  import adc_osr_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = ADC_OSR_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             osr_data_in,
  input  logic                          osr_done_in,
  input  logic                          enable_in,
  input  logic                          rd_ready_in,
  output logic                          rd_valid_out,
  output logic [DATA_W-1:0]             rd_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  input  logic                          overflow_clr_in,
  output logic [15:0]                   sample_count_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic capture;

  adc_strobe_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_strobe_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (osr_done_in),
    .pulse_out (capture)
  );

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       count_q, count_d;
  logic              push, pop, full, wr_en, drop;

  always_comb begin
    push  = capture & enable_in;
    full  = (level_q == FULL_LVL);
    pop   = (level_q != '0) & rd_ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;

    wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = wr_en ? count_q + 16'd1      : count_q;

    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !wr_en) level_d = level_q - LVL_W'(1);

    overflow_d = overflow_q;
    if (overflow_clr_in) overflow_d = 1'b0;
    if (drop)            overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= osr_data_in;
  end

  assign rd_valid_out     = (level_q != '0);
  assign rd_data_out      = rd_valid_out ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_out   = level_q;
  assign overflow_out     = overflow_q;
  assign sample_count_out = count_q;

endmodule

// File: tb/tb_adc_osr_reader.sv
// Directed and randomized checks of adc_osr_reader against a queue-based
// reference model of the reader's observable behaviour.
module tb_adc_osr_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] osr_data_in;
  logic        osr_done_in;
  logic        enable_in;
  logic        rd_ready_in;
  logic        rd_valid_out;
  logic [15:0] rd_data_out;
  logic [2:0]  fifo_level_out;
  logic        overflow_out;
  logic        overflow_clr_in;
  logic [15:0] sample_count_out;

  adc_osr_reader #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .DATA_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .osr_data_in      (osr_data_in),
    .osr_done_in      (osr_done_in),
    .enable_in        (enable_in),
    .rd_ready_in      (rd_ready_in),
    .rd_valid_out     (rd_valid_out),
    .rd_data_out      (rd_data_out),
    .fifo_level_out   (fifo_level_out),
    .overflow_out     (overflow_out),
    .overflow_clr_in  (overflow_clr_in),
    .sample_count_out (sample_count_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents in order, sticky flag, accepted count, and the
  // done level seen at the last three clock edges.
  logic [15:0] mq[$];
  logic        m_ovf;
  logic [15:0] m_cnt;
  logic        h1, h2, h3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/valid"}, 32'(rd_valid_out), 32'(mq.size() != 0));
    chk({tag, "/data"},  32'(rd_data_out),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, "/level"}, 32'(fifo_level_out), 32'(mq.size()));
    chk({tag, "/ovf"},   32'(overflow_out), 32'(m_ovf));
    chk({tag, "/count"}, 32'(sample_count_out), 32'(m_cnt));
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = 16'd0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  // One clock: predict the edge from the current inputs, then check at negedge.
  task automatic step(input string tag);
    bit cap, pu, po, was_full;
    cap      = h2 & ~h3;
    h3 = h2; h2 = h1; h1 = osr_done_in;
    pu       = cap & enable_in;
    was_full = (mq.size() == DEPTH);
    po       = (mq.size() != 0) && rd_ready_in;
    if (po) void'(mq.pop_front());
    if (overflow_clr_in) m_ovf = 1'b0;
    if (pu) begin
      if (!was_full || po) begin
        mq.push_back(osr_data_in);
        m_cnt = m_cnt + 16'd1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Done high two cycles, low two; the capture edge is the third step.
  task automatic strobe(input string tag, input logic [15:0] d,
                        input logic rdy_cap, input logic clr_cap);
    osr_data_in = d;
    osr_done_in = 1'b1;
    step(tag);
    step(tag);
    osr_done_in     = 1'b0;
    rd_ready_in     = rdy_cap;
    overflow_clr_in = clr_cap;
    step(tag);
    rd_ready_in     = 1'b0;
    overflow_clr_in = 1'b0;
    step(tag);
  endtask

  task automatic drain(input string tag, input int n);
    rd_ready_in = 1'b1;
    for (int i = 0; i < n; i++) step(tag);
    rd_ready_in = 1'b0;
  endtask

  logic [15:0] rnd;

  initial begin
    rst_n = 1'b0;
    osr_data_in = '0; osr_done_in = 1'b0; enable_in = 1'b1;
    rd_ready_in = 1'b0; overflow_clr_in = 1'b0;
    model_clear();
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");

    // Single result with the long done pulse; explicit latency points too.
    osr_data_in = 16'hABC0;
    osr_done_in = 1'b1;
    step("single_e0");
    step("single_e1");
    chk("single_not_yet", 32'(rd_valid_out), 32'd0);
    step("single_e2");
    chk("single_valid", 32'(rd_valid_out), 32'd1);
    chk("single_data", 32'(rd_data_out), 32'hABC0);
    for (int i = 0; i < 3; i++) step("single_hold");
    osr_done_in = 1'b0;
    for (int i = 0; i < 4; i++) step("single_low");
    drain("single_pop", 1);
    chk("single_empty", 32'(fifo_level_out), 32'd0);

    // Fill and overflow, then drain in order.
    for (int i = 1; i <= 5; i++) strobe("fill", 16'(i), 1'b0, 1'b0);
    chk("fill_level", 32'(fifo_level_out), 32'd4);
    chk("fill_ovf", 32'(overflow_out), 32'd1);
    chk("fill_count", 32'(sample_count_out), 32'd5);
    drain("fill_drain", 5);

    // Full with simultaneous push and pop.
    overflow_clr_in = 1'b1;
    step("clr");
    overflow_clr_in = 1'b0;
    for (int i = 1; i <= 4; i++) strobe("full_fill", 16'(i), 1'b0, 1'b0);
    strobe("full_pp", 16'd9, 1'b1, 1'b0);
    chk("full_pp_ovf", 32'(overflow_out), 32'd0);
    chk("full_pp_level", 32'(fifo_level_out), 32'd4);
    chk("full_pp_head", 32'(rd_data_out), 32'd2);
    drain("full_pp_drain", 5);

    // Enable gating.
    enable_in = 1'b0;
    for (int i = 0; i < 3; i++) strobe("gated", 16'h1111 * 16'(i + 1), 1'b0, 1'b0);
    enable_in = 1'b1;
    strobe("enabled", 16'h7E57, 1'b0, 1'b0);
    chk("enabled_level", 32'(fifo_level_out), 32'd1);

    // Clear and drop in the same cycle: set wins; a later clear takes effect.
    for (int i = 0; i < 3; i++) strobe("ovc_fill", 16'h0F00 + 16'(i), 1'b0, 1'b0);
    strobe("ovc_drop", 16'hDEAD, 1'b0, 1'b1);
    chk("ovc_set_wins", 32'(overflow_out), 32'd1);
    overflow_clr_in = 1'b1;
    step("ovc_clear");
    overflow_clr_in = 1'b0;
    chk("ovc_cleared", 32'(overflow_out), 32'd0);
    drain("ovc_drain", 4);

    // Randomized strobes, enables, ready and clears.
    for (int n = 0; n < 60; n++) begin
      rnd = 16'($urandom);
      enable_in = ($urandom_range(0, 7) != 0);
      strobe("rand", rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        rd_ready_in = 1'($urandom_range(0, 1));
        overflow_clr_in = ($urandom_range(0, 5) == 0);
        step("rand_gap");
      end
      rd_ready_in = 1'b0;
      overflow_clr_in = 1'b0;
    end
    enable_in = 1'b1;
    drain("rand_drain", 5);

    // Reset mid-stream with three entries and a done in flight.
    for (int i = 0; i < 3; i++) strobe("pre_rst", 16'h5A00 + 16'(i), 1'b0, 1'b0);
    osr_data_in = 16'h5AFF;
    osr_done_in = 1'b1;
    step("inflight");
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rd_valid_out), 32'd0);
    chk("rst_data", 32'(rd_data_out), 32'd0);
    chk("rst_level", 32'(fifo_level_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);
    chk("rst_count", 32'(sample_count_out), 32'd0);
    model_clear();
    @(negedge clk);
    osr_done_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("post_rst");

    // Counter wrap: preload the count, then one accepted push.
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    m_cnt = 16'hFFFF;
    chk("wrap_pre", 32'(sample_count_out), 32'hFFFF);
    strobe("wrap", 16'h0042, 1'b0, 1'b0);
    chk("wrap_zero", 32'(sample_count_out), 32'd0);
    drain("wrap_drain", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
